// File: rtl/seven_output_oc_enum.sv
`default_nettype none
// ============================================================================
// Module      : seven_output_oc_enum
// Description : Enumerates, in ascending order, every 7-bit word whose
//               population count equals the requested 3-bit ones count.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_output_oc_enum (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y2,
  input  logic       y1,
  input  logic       y0,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       valid,
  output logic       last,
  output logic [5:0] idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_k;
  logic [2:0] w_k_nxt;
  logic [2:0] w_k_in;
  logic [6:0] r_word;
  logic [6:0] w_word_nxt;
  logic [5:0] r_idx;
  logic [5:0] w_idx_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_last;
  logic [6:0] w_top;
  logic [6:0] w_succ;
  logic [6:0] w_t;
  logic [6:0] w_t1;
  logic [6:0] w_fill;
  logic [2:0] w_ctz;

  assign w_k_in = {y2, y1, y0};
  assign w_top  = ~(7'h7F >> r_k);
  assign w_last = (r_state == S_RUN) && (r_word == w_top);

  // Next combination with the same popcount: bump the lowest run of ones
  // left by one and re-pack the remaining ones at the bottom. The 7-bit
  // arithmetic only wraps on the final word, whose successor is never used.
  always_comb begin
    w_ctz = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_word[i]) w_ctz = 3'(i);
    end
    w_t    = r_word | (r_word - 7'd1);
    w_t1   = w_t + 7'd1;
    w_fill = ((~w_t & w_t1) - 7'd1) >> (w_ctz + 3'd1);
    w_succ = w_t1 | w_fill;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_k_nxt     = w_k_in;
          w_word_nxt  = 7'h7F >> (3'd7 - w_k_in);
          w_idx_nxt   = 6'd0;
        end
      end
      S_RUN: begin
        if (ready) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_word_nxt = w_succ;
            w_idx_nxt  = r_idx + 6'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 3'd0;
      r_word  <= 7'd0;
      r_idx   <= 6'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_word  <= w_word_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign {a, b, c, d, e, f, g} = r_word;
  assign valid = (r_state == S_RUN);
  assign busy  = (r_state == S_RUN);
  assign last  = w_last;
  assign idx   = r_idx;
  assign done  = r_done;

endmodule
`default_nettype wire
